// File: rtl/canny_vip_pkg.sv
// Shared definitions for the Canny VIP output stages: packet types, stage FSM
// states and the default Avalon-ST data width.
package canny_vip_pkg;

   localparam logic [3:0] PKT_VIDEO = 4'h0;
   localparam logic [3:0] PKT_CTRL  = 4'hF;

   localparam int DEF_BITS_PER_SYMBOL  = 8;
   localparam int DEF_SYMBOLS_PER_BEAT = 3;

   function automatic int vip_dw(input int bits_per_symbol, input int symbols_per_beat);
      return bits_per_symbol * symbols_per_beat;
   endfunction

   localparam int DEF_DW = vip_dw(DEF_BITS_PER_SYMBOL, DEF_SYMBOLS_PER_BEAT);

   typedef enum logic [1:0] {
      StIdle,
      StVideo,
      StPass
   } vip_state_e;

endpackage

// File: rtl/vip_skid_buffer.sv
// Output register plus one-entry skid register for Avalon-ST stages; in_ready is
// registered and means "skid empty", so upstream timing never sees out_ready.
module vip_skid_buffer #(
   parameter int W = 26
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         out_valid_q, out_valid_d;
   logic [W-1:0] out_data_q, out_data_d;
   logic         skid_valid_q, skid_valid_d;
   logic [W-1:0] skid_data_q, skid_data_d;
   logic         ready_q, ready_d;
   logic         accept;

   assign accept = in_valid && ready_q;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (!out_valid_q || out_ready) begin
         // in_ready is low while the skid is full, so no accept can coincide here
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = accept;
            if (accept) begin
               out_data_d = in_data;
            end
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_data_d  = in_data;
      end
      ready_d = !skid_valid_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         ready_q      <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         ready_q      <= ready_d;
      end
   end

   assign in_ready  = ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: rtl/canny_roi_mask.sv
// Avalon-ST pass-through that replaces video pixels outside a fixed rectangular
// region of interest with MASK_VALUE, and flags frame completion and size errors.
module canny_roi_mask
   import canny_vip_pkg::*;
#(
   parameter int BITS_PER_SYMBOL  = DEF_BITS_PER_SYMBOL,
   parameter int SYMBOLS_PER_BEAT = DEF_SYMBOLS_PER_BEAT,
   parameter int WIDTH            = 1280,
   parameter int HEIGHT           = 720,
   parameter int ROI_X0           = 0,
   parameter int ROI_X1           = 1279,
   parameter int ROI_Y0           = 360,
   parameter int ROI_Y1           = 719,
   parameter logic [vip_dw(BITS_PER_SYMBOL, SYMBOLS_PER_BEAT)-1:0] MASK_VALUE = '0
) (
   input  logic                                                 clk,
   input  logic                                                 rst,
   output logic                                                 din_ready,
   input  logic                                                 din_valid,
   input  logic                                                 din_sop,
   input  logic                                                 din_eop,
   input  logic [vip_dw(BITS_PER_SYMBOL, SYMBOLS_PER_BEAT)-1:0] din_data,
   input  logic                                                 dout_ready,
   output logic                                                 dout_valid,
   output logic                                                 dout_sop,
   output logic                                                 dout_eop,
   output logic [vip_dw(BITS_PER_SYMBOL, SYMBOLS_PER_BEAT)-1:0] dout_data,
   output logic                                                 frame_done,
   output logic                                                 size_err
);

   localparam int          DW           = vip_dw(BITS_PER_SYMBOL, SYMBOLS_PER_BEAT);
   localparam int          XW           = $clog2(WIDTH + 1);
   localparam int          YW           = $clog2(HEIGHT + 1);
   localparam logic [31:0] FRAME_PIXELS = 32'(WIDTH * HEIGHT);

   vip_state_e      state_q, state_d;
   logic [XW-1:0]   x_q, x_d;
   logic [YW-1:0]   y_q, y_d;
   logic [31:0]     cnt_q, cnt_d;
   logic            frame_done_q, frame_done_d;
   logic            size_err_q, size_err_d;
   logic            skid_in_ready;
   logic            accept;
   logic            is_hdr;
   logic            hdr_video;
   logic            is_payload;
   logic            in_roi;
   logic [DW-1:0]   out_data_c;
   logic [DW+1:0]   skid_out;

   assign accept     = din_valid && skid_in_ready;
   assign is_hdr     = accept && din_sop;
   assign hdr_video  = din_data[3:0] == PKT_VIDEO;
   assign is_payload = accept && !din_sop && (state_q == StVideo);

   // y saturates at HEIGHT, so overlong frames fall outside the ROI
   assign in_roi = (int'(x_q) >= ROI_X0) && (int'(x_q) <= ROI_X1) &&
                   (int'(y_q) >= ROI_Y0) && (int'(y_q) <= ROI_Y1) &&
                   (int'(y_q) < HEIGHT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // A sop is always a fresh header, even mid-packet
   always_comb begin
      state_d = state_q;
      if (accept) begin
         if (din_sop) begin
            if (din_eop) begin
               state_d = StIdle;
            end else if (hdr_video) begin
               state_d = StVideo;
            end else begin
               state_d = StPass;
            end
         end else if (din_eop) begin
            state_d = StIdle;
         end
      end
   end

   always_comb begin
      out_data_c   = din_data;
      frame_done_d = 1'b0;
      size_err_d   = 1'b0;
      if (is_payload && !in_roi) begin
         out_data_c = MASK_VALUE;
      end
      if (accept && din_eop) begin
         if (din_sop && hdr_video) begin
            frame_done_d = 1'b1;
            size_err_d   = 1'b1;
         end else if (is_payload) begin
            frame_done_d = 1'b1;
            size_err_d   = (cnt_q + 32'd1) != FRAME_PIXELS;
         end
      end
   end

   always_comb begin
      x_d   = x_q;
      y_d   = y_q;
      cnt_d = cnt_q;
      if (is_hdr) begin
         x_d   = '0;
         y_d   = '0;
         cnt_d = '0;
      end else if (is_payload) begin
         cnt_d = cnt_q + 32'd1;
         if (int'(x_q) == WIDTH - 1) begin
            x_d = '0;
            if (int'(y_q) < HEIGHT) begin
               y_d = y_q + YW'(1);
            end
         end else begin
            x_d = x_q + XW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_q          <= '0;
         y_q          <= '0;
         cnt_q        <= '0;
         frame_done_q <= 1'b0;
         size_err_q   <= 1'b0;
      end else begin
         x_q          <= x_d;
         y_q          <= y_d;
         cnt_q        <= cnt_d;
         frame_done_q <= frame_done_d;
         size_err_q   <= size_err_d;
      end
   end

   vip_skid_buffer #(
      .W(DW + 2)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .in_valid (din_valid),
      .in_ready (skid_in_ready),
      .in_data  ({din_sop, din_eop, out_data_c}),
      .out_valid(dout_valid),
      .out_ready(dout_ready),
      .out_data (skid_out)
   );

   assign din_ready  = skid_in_ready;
   assign dout_sop   = skid_out[DW+1];
   assign dout_eop   = skid_out[DW];
   assign dout_data  = skid_out[DW-1:0];
   assign frame_done = frame_done_q;
   assign size_err   = size_err_q;

endmodule

// File: tb/tb_canny_roi_mask.sv
// Scoreboard bench for canny_roi_mask on a 4x3 frame with ROI x1..2, y1..1.
module tb_canny_roi_mask;

   localparam int          TW   = 4;
   localparam int          TH   = 3;
   localparam int          X0   = 1;
   localparam int          X1   = 2;
   localparam int          Y0   = 1;
   localparam int          Y1   = 1;
   localparam logic [23:0] MASK = 24'h000000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        din_ready;
   logic        din_valid = 1'b0;
   logic        din_sop = 1'b0;
   logic        din_eop = 1'b0;
   logic [23:0] din_data = '0;
   logic        dout_ready = 1'b1;
   logic        dout_valid;
   logic        dout_sop;
   logic        dout_eop;
   logic [23:0] dout_data;
   logic        frame_done;
   logic        size_err;

   canny_roi_mask #(
      .BITS_PER_SYMBOL (8),
      .SYMBOLS_PER_BEAT(3),
      .WIDTH           (TW),
      .HEIGHT          (TH),
      .ROI_X0          (X0),
      .ROI_X1          (X1),
      .ROI_Y0          (Y0),
      .ROI_Y1          (Y1),
      .MASK_VALUE      (MASK)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .din_ready (din_ready),
      .din_valid (din_valid),
      .din_sop   (din_sop),
      .din_eop   (din_eop),
      .din_data  (din_data),
      .dout_ready(dout_ready),
      .dout_valid(dout_valid),
      .dout_sop  (dout_sop),
      .dout_eop  (dout_eop),
      .dout_data (dout_data),
      .frame_done(frame_done),
      .size_err  (size_err)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   int          ready_mode = 0;
   logic [25:0] exp_q[$];

   // reference model state: 0 idle, 1 video, 2 pass
   int          m_state = 0;
   int          m_pix = 0;
   logic        fd_exp = 1'b0;
   logic        se_exp = 1'b0;
   logic        lat_pending = 1'b0;
   logic        stall_prev = 1'b0;
   logic [25:0] stall_val = '0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
      end
   endtask

   task automatic model_beat(input logic sop, input logic eop, input logic [23:0] d);
      logic [23:0] o;
      logic [3:0]  t;
      int          x;
      int          y;
      o = d;
      t = d[3:0];
      if (sop) begin
         m_pix = 0;
         if (t == 4'h0) begin
            m_state = eop ? 0 : 1;
            if (eop) begin
               fd_exp = 1'b1;
               se_exp = 1'b1;
            end
         end else begin
            m_state = eop ? 0 : 2;
         end
      end else if (m_state == 1) begin
         x = m_pix % TW;
         y = m_pix / TW;
         if (y > TH) y = TH;
         if (!(x >= X0 && x <= X1 && y >= Y0 && y <= Y1 && y < TH)) o = MASK;
         m_pix++;
         if (eop) begin
            fd_exp  = 1'b1;
            se_exp  = (m_pix != TW * TH);
            m_state = 0;
         end
      end else if (eop) begin
         m_state = 0;
      end
      exp_q.push_back({sop, eop, o});
   endtask

   // sink observer: feeds the model and checks status pulses and latency
   always @(negedge clk) begin
      if (!rst) begin
         exp_q.delete();
         m_state     = 0;
         m_pix       = 0;
         fd_exp      = 1'b0;
         se_exp      = 1'b0;
         lat_pending = 1'b0;
      end else begin
         n_cmp++;
         if (frame_done !== fd_exp || size_err !== se_exp) begin
            n_err++;
            $display("FAIL status: frame_done,size_err=%b%b expected %b%b at %0t",
                     frame_done, size_err, fd_exp, se_exp, $time);
         end
         if (lat_pending) check("latency dout_valid", 32'(dout_valid), 32'd1);
         fd_exp      = 1'b0;
         se_exp      = 1'b0;
         lat_pending = 1'b0;
         if (din_valid && din_ready) begin
            model_beat(din_sop, din_eop, din_data);
            lat_pending = (ready_mode == 0) && dout_ready;
         end
      end
   end

   // source monitor: pops the scoreboard on every emitted beat
   always @(negedge clk) begin
      logic [25:0] got;
      logic [25:0] e;
      if (!rst) begin
         stall_prev = 1'b0;
      end else begin
         got = {dout_sop, dout_eop, dout_data};
         if (stall_prev) begin
            n_cmp++;
            if (!dout_valid || got !== stall_val) begin
               n_err++;
               $display("FAIL stall hold: got v=%b %h expected v=1 %h at %0t",
                        dout_valid, got, stall_val, $time);
            end
         end
         stall_prev = dout_valid && !dout_ready;
         stall_val  = got;
         if (dout_valid && dout_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL output beat: got %h expected none at %0t", got, $time);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  n_err++;
                  $display("FAIL output beat: got %h expected %h at %0t", got, e, $time);
               end
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       dout_ready = 1'b1;
         1:       dout_ready = ~dout_ready;
         default: dout_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   // all driver tasks start and end 1 time unit after a rising edge
   task automatic send(input logic sop, input logic eop, input logic [23:0] d);
      int n;
      din_valid = 1'b1;
      din_sop   = sop;
      din_eop   = eop;
      din_data  = d;
      n = 0;
      @(negedge clk);
      while (din_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         n_cmp++;
         n_err++;
         $display("FAIL sink handshake: got no din_ready expected within 100 cycles");
      end
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      din_sop   = 1'b0;
      din_eop   = 1'b0;
   endtask

   task automatic idle(input int n);
      din_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic video(input int len, input bit rnd);
      logic [31:0] r;
      logic [23:0] d;
      r = $urandom();
      send(1'b1, len == 0, rnd ? {r[23:4], 4'h0} : 24'h000000);
      for (int i = 0; i < len; i++) begin
         r = $urandom();
         d = rnd ? r[23:0] : 24'(i + 1) * 24'h010101;
         send(1'b0, i == len - 1, d);
         if (rnd && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
   endtask

   task automatic ctrl(input int len, input logic [3:0] t);
      logic [31:0] r;
      r = $urandom();
      send(1'b1, len == 0, {r[23:4], t});
      for (int i = 0; i < len; i++) begin
         r = $urandom();
         send(1'b0, i == len - 1, r[23:0]);
      end
   endtask

   initial begin
      int n;
      int k;
      logic [31:0] r;
      repeat (3) @(posedge clk);
      #1;
      check("reset din_ready", 32'(din_ready), 32'd0);
      check("reset dout_valid", 32'(dout_valid), 32'd0);
      check("reset dout_sop", 32'(dout_sop), 32'd0);
      check("reset dout_eop", 32'(dout_eop), 32'd0);
      check("reset dout_data", 32'(dout_data), 32'd0);
      check("reset frame_done", 32'(frame_done), 32'd0);
      check("reset size_err", 32'(size_err), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("release din_ready low", 32'(din_ready), 32'd0);
      @(posedge clk);
      #1;
      check("release din_ready high", 32'(din_ready), 32'd1);

      // directed: full frame, control packet, stalled frame, short frame then full
      video(12, 1'b0);
      idle(3);
      ctrl(3, 4'hF);
      idle(2);
      ready_mode = 1;
      video(12, 1'b0);
      idle(4);
      ready_mode = 0;
      idle(3);
      video(10, 1'b0);
      video(12, 1'b0);
      idle(3);

      // reset mid-frame after 5 beats
      ready_mode = 1;
      send(1'b1, 1'b0, 24'h000000);
      for (int i = 0; i < 4; i++) send(1'b0, 1'b0, 24'(i + 1) * 24'h010101);
      rst = 1'b0;
      #1;
      check("mid reset dout_valid", 32'(dout_valid), 32'd0);
      check("mid reset din_ready", 32'(din_ready), 32'd0);
      @(posedge clk);
      #1;
      check("held reset din_ready", 32'(din_ready), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("re-release din_ready low", 32'(din_ready), 32'd0);
      @(posedge clk);
      #1;
      check("re-release din_ready high", 32'(din_ready), 32'd1);
      ready_mode = 0;
      video(12, 1'b0);
      idle(3);

      // randomized packet mix under random backpressure
      ready_mode = 2;
      for (int p = 0; p < 60; p++) begin
         k = $urandom_range(0, 9);
         if (k <= 5) begin
            video(($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : 12, 1'b1);
         end else if (k <= 7) begin
            ctrl($urandom_range(0, 5), 4'($urandom_range(1, 15)));
         end else if (k == 8) begin
            for (int i = 0; i < $urandom_range(1, 3); i++) begin
               r = $urandom();
               send(1'b0, $urandom_range(0, 1) == 1, r[23:0]);
            end
         end else begin
            r = $urandom();
            send(1'b1, 1'b0, {r[23:4], 4'h0});
            for (int i = 0; i < $urandom_range(0, 5); i++) begin
               r = $urandom();
               send(1'b0, 1'b0, r[23:0]);
            end
            video(12, 1'b1);
         end
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end

      ready_mode = 0;
      idle(1);
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: got %0d beats outstanding expected 0", exp_q.size());
      end
      idle(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
